// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - handshaked registered ALU decode-and-execute stage
// Define ALU_MUL_EN to build the iterative shift-add multiplier (funct 011000).
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_SLT, OP_MUL, OP_ILL
  } op_t;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int unsigned CNT_W = $clog2(WIDTH);
`else
  typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

  state_t           state;
  state_t           state_next;
  op_t              op;
  logic             accept;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_res;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_step;
  logic [CNT_W-1:0] cnt;
  logic             last;

  assign acc_step = mplier[0] ? (acc + mcand) : acc;
  assign last     = (cnt == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    op = OP_ILL;
    case (alu_op)
      3'b000, 3'b011: op = OP_ADD;
      3'b001, 3'b100: op = OP_SUB;
      3'b010: begin
        case (funct)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_XOR;
          6'b100101: op = OP_OR;
          6'b101010: op = OP_SLT;
`ifdef ALU_MUL_EN
          6'b011000: op = OP_MUL;
`endif
          default:   op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  always_comb begin
    slt_bit = ($signed(a) < $signed(b));
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_XOR:  alu_res = a ^ b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_res = '0;
    endcase
  end

  // DONE with out_ready behaves like IDLE so results can stream one per cycle.
  always_comb begin
    state_next = state;
    in_ready   = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    accept     = in_valid && in_ready;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          state_next = (op == OP_MUL) ? BUSY : DONE;
`else
          state_next = DONE;
`endif
        end else if ((state == DONE) && out_ready) begin
          state_next = IDLE;
        end
      end
`ifdef ALU_MUL_EN
      BUSY: begin
        if (last) state_next = DONE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
`ifdef ALU_MUL_EN
      acc     <= '0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
`endif
    end else begin
      if (accept && (op != OP_MUL)) begin
        result  <= alu_res;
        zero    <= (alu_res == '0);
        illegal <= (op == OP_ILL);
      end
`ifdef ALU_MUL_EN
      if (accept && (op == OP_MUL)) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end
      if (state == BUSY) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          result  <= acc_step;
          zero    <= (acc_step == '0);
          illegal <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
// Honours ALU_MUL_EN to select multiply or illegal expectations for funct 011000.
`timescale 1ns/1ps
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model(input logic [2:0] op, input logic [5:0] f,
                                input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic il, output int lat);
    longint unsigned p;
    r = '0; il = 1'b0; lat = 1;
    if (op == 3'd0 || op == 3'd3) r = x + y;
    else if (op == 3'd1 || op == 3'd4) r = x - y;
    else if (op == 3'd2) begin
      case (f)
        6'd32: r = x + y;
        6'd34: r = x - y;
        6'd36: r = x ^ y;
        6'd37: r = x | y;
        6'd42: r = (int'(x) < int'(y)) ? 1 : 0;
`ifdef ALU_MUL_EN
        6'd24: begin
          p = longint'(x) * longint'(y);
          r = p[W-1:0];
          lat = W + 1;
        end
`endif
        default: il = 1'b1;
      endcase
    end else il = 1'b1;
  endfunction

  // Presents one op, waits for its result while holding it, then releases it.
  task automatic send(input logic [2:0] op, input logic [5:0] f,
                      input logic [W-1:0] x, input logic [W-1:0] y,
                      output int lat, output logic [W-1:0] r, output logic z, output logic il);
    int n;
    alu_op = op; funct = f; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    r = result; z = zero; il = illegal;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; alu_op = 3'd0; funct = 6'd0; a = 1; b = 2; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if ({result, zero, illegal, out_valid} !== {{W{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL post_reset_outputs: got result=%h zero=%b illegal=%b out_valid=%b expected 0 0 0 0",
               result, zero, illegal, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_decode();
    logic [2:0]   ops [0:7] = '{3'b000, 3'b011, 3'b001, 3'b100, 3'b010, 3'b010, 3'b010, 3'b010};
    logic [5:0]   fns [0:7] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'b100100, 6'b100101, 6'b100000, 6'b100010};
    logic [W-1:0] exp [0:7] = '{32'h12, 32'h12, 32'hC, 32'hC, 32'hC, 32'hF, 32'h12, 32'hC};
    logic [W-1:0] r;
    logic z, il;
    int lat;
    for (int i = 0; i < 8; i++) begin
      send(ops[i], fns[i], 32'h0000000F, 32'h00000003, lat, r, z, il);
      checks++;
      if (r !== exp[i] || z !== 1'b0 || il !== 1'b0 || lat != 1) begin
        errors++;
        $display("FAIL decode_%0d: got result=%h zero=%b illegal=%b lat=%0d expected %h 0 0 1",
                 i, r, z, il, lat, exp[i]);
      end
    end
    send(3'b010, 6'b100010, 32'h1234ABCD, 32'h1234ABCD, lat, r, z, il);
    checks++;
    if (r !== '0 || z !== 1'b1 || il !== 1'b0) begin
      errors++;
      $display("FAIL sub_equal: got result=%h zero=%b illegal=%b expected 0 1 0", r, z, il);
    end
  endtask

  task automatic test_slt_wrap();
    logic [W-1:0] r;
    logic z, il;
    int lat;
    send(3'b010, 6'b101010, 32'hFFFFFFFF, 32'h1, lat, r, z, il);
    checks++;
    if (r !== 32'h1 || z !== 1'b0) begin errors++; $display("FAIL slt_neg: got result=%h zero=%b expected 1 0", r, z); end
    send(3'b010, 6'b101010, 32'h1, 32'hFFFFFFFF, lat, r, z, il);
    checks++;
    if (r !== 32'h0 || z !== 1'b1) begin errors++; $display("FAIL slt_pos: got result=%h zero=%b expected 0 1", r, z); end
    send(3'b000, 6'd0, 32'hFFFFFFFF, 32'h1, lat, r, z, il);
    checks++;
    if (r !== 32'h0 || z !== 1'b1) begin errors++; $display("FAIL add_wrap: got result=%h zero=%b expected 0 1", r, z); end
  endtask

  task automatic test_illegal();
    logic [2:0] iops [0:3] = '{3'b010, 3'b101, 3'b110, 3'b111};
    logic [5:0] ifns [0:3] = '{6'b000111, 6'b100000, 6'd0, 6'b101010};
    logic [W-1:0] r;
    logic z, il;
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(iops[i], ifns[i], 32'hDEADBEEF, 32'h5, lat, r, z, il);
      checks++;
      if (r !== '0 || z !== 1'b1 || il !== 1'b1 || lat != 1) begin
        errors++;
        $display("FAIL illegal_%0d: got result=%h zero=%b illegal=%b lat=%0d expected 0 1 1 1", i, r, z, il, lat);
      end
    end
    send(3'b000, 6'd0, 32'h4, 32'h5, lat, r, z, il);
    checks++;
    if (r !== 32'h9 || il !== 1'b0 || z !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: got result=%h zero=%b illegal=%b expected 9 0 0", r, z, il);
    end
  endtask

  task automatic test_random();
    logic [2:0]   op;
    logic [5:0]   f;
    logic [W-1:0] x, y, r, er;
    logic         z, il, eil;
    int           lat, elat, k;
    logic [5:0]   fl [0:5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd24};
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 10);
      f = 6'($urandom);
      if (k < 4) op = (k == 0) ? 3'd0 : (k == 1) ? 3'd3 : (k == 2) ? 3'd1 : 3'd4;
      else if (k < 10) begin op = 3'd2; f = fl[k-4]; end
      else op = 3'($urandom);
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      if ($urandom_range(0, 4) == 0) x = 32'h80000000;
      model(op, f, x, y, er, eil, elat);
      send(op, f, x, y, lat, r, z, il);
      checks++;
      if (r !== er || z !== (er == '0) || il !== eil || lat != elat) begin
        errors++;
        $display("FAIL random_%0d op=%b funct=%b a=%h b=%h: got %h z=%b il=%b lat=%0d expected %h z=%b il=%b lat=%0d",
                 i, op, f, x, y, r, z, il, lat, er, (er == '0), eil, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xs [0:3];
    logic [W-1:0] ys [0:3];
    logic [W-1:0] e;
    alu_op = 3'd0; funct = 6'd0; a = 32'd5; b = 32'd6; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    a = 32'd100; b = 32'd200;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd11 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: got out_valid=%b result=%h in_ready=%b expected 1 b 0", i, out_valid, result, in_ready);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin xs[i] = $urandom; ys[i] = $urandom; end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = xs[i]; b = ys[i]; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d: got %b expected 1", i, in_ready); end
      @(negedge clk);
      e = xs[i] + ys[i];
      checks++;
      if (out_valid !== 1'b1 || result !== e) begin
        errors++;
        $display("FAIL stream_%0d: got out_valid=%b result=%h expected 1 %h", i, out_valid, result, e);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got out_valid=%b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_mul();
    logic [W-1:0] r;
    logic z, il;
    int lat;
`ifdef ALU_MUL_EN
    send(3'b010, 6'b011000, 32'd7, 32'd6, lat, r, z, il);
    checks++;
    if (r !== 32'd42 || lat != W + 1 || il !== 1'b0) begin
      errors++;
      $display("FAIL mul_7x6: got result=%0d lat=%0d illegal=%b expected 42 %0d 0", r, lat, il, W + 1);
    end
    send(3'b010, 6'b011000, 32'hFFFFFFFF, 32'd2, lat, r, z, il);
    checks++;
    if (r !== 32'hFFFFFFFE || z !== 1'b0) begin
      errors++;
      $display("FAIL mul_wrap: got result=%h zero=%b expected fffffffe 0", r, z);
    end
    alu_op = 3'b010; funct = 6'b011000; a = $urandom; b = $urandom; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mul_busy: got in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mul_reset: got out_valid=%b result=%h zero=%b illegal=%b in_ready=%b expected 0 0 0 0 1",
               out_valid, result, zero, illegal, in_ready);
    end
    repeat (W + 2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_discard: got out_valid=%b expected 0", out_valid); end
`else
    send(3'b010, 6'b011000, 32'd7, 32'd6, lat, r, z, il);
    checks++;
    if (r !== '0 || z !== 1'b1 || il !== 1'b1 || lat != 1) begin
      errors++;
      $display("FAIL mul_disabled: got result=%h zero=%b illegal=%b lat=%0d expected 0 1 1 1", r, z, il, lat);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_decode();
    test_slt_wrap();
    test_illegal();
    test_back_to_back();
    test_mul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
